// File: rtl/conv_sequencer_pkg.sv
// Shared types and constants for the convolution layer sequencer and its kernel bank.
// Kernel matrices travel as packed structs so they plug straight into conv_control.
package conv_sequencer_pkg;

   localparam int PIXEL_WIDTH_OUT     = 16;
   localparam int MAX_RESOLUTION_BITS = 16;
   localparam int COEFS_PER_KERNEL    = 9;
   localparam int COEF_IDX_W          = $clog2(COEFS_PER_KERNEL);

   typedef struct packed {
      logic [PIXEL_WIDTH_OUT-1:0] p0;
      logic [PIXEL_WIDTH_OUT-1:0] p1;
      logic [PIXEL_WIDTH_OUT-1:0] p2;
   } vector_3;

   typedef struct packed {
      vector_3 vector0;
      vector_3 vector1;
      vector_3 vector2;
   } matrix_3x3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP,
      DONE
   } seq_state_t;

   // True on the ninth (final) coefficient slot of a kernel.
   function automatic logic is_last_coef(input logic [COEF_IDX_W-1:0] coef_idx);
      return coef_idx == COEF_IDX_W'(COEFS_PER_KERNEL - 1);
   endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// Register file of NUM_KERNELS 3x3 kernels: one coefficient write port and one
// asynchronous whole-kernel read port. Coefficients are stored verbatim.
module conv_kernel_bank
   import conv_sequencer_pkg::*;
#(
   parameter int NUM_KERNELS = 2,
   parameter int KIDX_W      = $clog2(NUM_KERNELS) + 1
) (
   input  logic                       clk_i,
   input  logic                       nreset_i,
   input  logic                       wr_en,
   input  logic [KIDX_W-1:0]          wr_kernel,
   input  logic [COEF_IDX_W-1:0]      wr_coef,
   input  logic [PIXEL_WIDTH_OUT-1:0] wr_data,
   input  logic [KIDX_W-1:0]          rd_kernel,
   output matrix_3x3                  rd_data
);

   localparam int AW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

   matrix_3x3  bank [NUM_KERNELS];
   logic [AW-1:0] wr_sel;
   logic [AW-1:0] rd_sel;
   logic          wr_in_range;
   logic          rd_in_range;

   assign wr_in_range = wr_kernel < KIDX_W'(NUM_KERNELS);
   assign rd_in_range = rd_kernel < KIDX_W'(NUM_KERNELS);
   assign wr_sel      = wr_kernel[AW-1:0];
   assign rd_sel      = rd_kernel[AW-1:0];

   // Coefficient slot n maps to vector n/3, element n%3.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         for (int k = 0; k < NUM_KERNELS; k++) begin
            bank[k] <= '0;
         end
      end else if (wr_en && wr_in_range) begin
         case (wr_coef)
            COEF_IDX_W'(0): bank[wr_sel].vector0.p0 <= wr_data;
            COEF_IDX_W'(1): bank[wr_sel].vector0.p1 <= wr_data;
            COEF_IDX_W'(2): bank[wr_sel].vector0.p2 <= wr_data;
            COEF_IDX_W'(3): bank[wr_sel].vector1.p0 <= wr_data;
            COEF_IDX_W'(4): bank[wr_sel].vector1.p1 <= wr_data;
            COEF_IDX_W'(5): bank[wr_sel].vector1.p2 <= wr_data;
            COEF_IDX_W'(6): bank[wr_sel].vector2.p0 <= wr_data;
            COEF_IDX_W'(7): bank[wr_sel].vector2.p1 <= wr_data;
            COEF_IDX_W'(8): bank[wr_sel].vector2.p2 <= wr_data;
            default: ;
         endcase
      end
   end

   assign rd_data = rd_in_range ? bank[rd_sel] : '0;

endmodule

// File: rtl/conv_sequencer.sv
// Layer scheduler in front of conv_control: loads a kernel bank serially, then runs
// conv_control once per kernel, dropping start_cnn_o for a gap between kernels.
module conv_sequencer
   import conv_sequencer_pkg::*;
#(
   parameter int NUM_KERNELS = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                           clk_i,
   input  logic                           nreset_i,
   input  logic                           cfg_valid_i,
   input  logic [PIXEL_WIDTH_OUT-1:0]     cfg_coef_i,
   output logic                           cfg_ready_o,
   output logic                           loaded_o,
   input  logic                           run_i,
   input  logic                           abort_i,
   input  logic [MAX_RESOLUTION_BITS-1:0] frame_px_i,
   input  logic                           conv_px_rdy_i,
   output matrix_3x3                      kernel_o,
   output logic                           start_cnn_o,
   output logic [$clog2(NUM_KERNELS):0]   kernel_idx_o,
   output logic                           busy_o,
   output logic                           layer_done_o,
   output logic                           done_o,
   output logic                           err_o
);

   localparam int KIDX_W = $clog2(NUM_KERNELS) + 1;
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [KIDX_W-1:0] LAST_KERNEL = KIDX_W'(NUM_KERNELS - 1);

   seq_state_t                     state;
   logic [MAX_RESOLUTION_BITS-1:0] frame_px;
   logic [MAX_RESOLUTION_BITS-1:0] px_cnt;
   logic [GAP_W-1:0]               gap_cnt;
   logic [KIDX_W-1:0]              wr_kernel;
   logic [COEF_IDX_W-1:0]          wr_coef;
   logic [KIDX_W-1:0]              rd_kernel;
   matrix_3x3                      rd_data;
   logic                           cfg_wr;

   // cfg_ready_o is only high in IDLE, so an accepted write never races a run.
   assign cfg_wr = cfg_valid_i & cfg_ready_o;

   // Look ahead to the kernel the next RUN will use: bank[0] on a fresh start,
   // bank[idx+1] when leaving GAP.
   assign rd_kernel = (state == GAP) ? kernel_idx_o + KIDX_W'(1) : '0;

   conv_kernel_bank #(
      .NUM_KERNELS (NUM_KERNELS),
      .KIDX_W      (KIDX_W)
   ) u_bank (
      .clk_i     (clk_i),
      .nreset_i  (nreset_i),
      .wr_en     (cfg_wr),
      .wr_kernel (wr_kernel),
      .wr_coef   (wr_coef),
      .wr_data   (cfg_coef_i),
      .rd_kernel (rd_kernel),
      .rd_data   (rd_data)
   );

   // Write pointer and loaded flag; the first slot of kernel 0 starts a reload.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         wr_kernel <= '0;
         wr_coef   <= '0;
         loaded_o  <= 1'b0;
      end else if (cfg_wr) begin
         if (wr_kernel == '0 && wr_coef == '0) begin
            loaded_o <= 1'b0;
         end
         if (is_last_coef(wr_coef)) begin
            wr_coef <= '0;
            if (wr_kernel == LAST_KERNEL) begin
               wr_kernel <= '0;
               loaded_o  <= 1'b1;
            end else begin
               wr_kernel <= wr_kernel + KIDX_W'(1);
            end
         end else begin
            wr_coef <= wr_coef + COEF_IDX_W'(1);
         end
      end
   end

   // Sequencer FSM with every output registered alongside the state.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state        <= IDLE;
         frame_px     <= '0;
         px_cnt       <= '0;
         gap_cnt      <= '0;
         kernel_idx_o <= '0;
         kernel_o     <= '0;
         start_cnn_o  <= 1'b0;
         busy_o       <= 1'b0;
         cfg_ready_o  <= 1'b1;
         layer_done_o <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         layer_done_o <= 1'b0;
         done_o       <= 1'b0;
         if (abort_i) begin
            state        <= IDLE;
            px_cnt       <= '0;
            gap_cnt      <= '0;
            kernel_idx_o <= '0;
            start_cnn_o  <= 1'b0;
            busy_o       <= 1'b0;
            cfg_ready_o  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (run_i) begin
                     if (loaded_o && frame_px_i != '0) begin
                        state        <= RUN;
                        frame_px     <= frame_px_i;
                        px_cnt       <= '0;
                        kernel_idx_o <= '0;
                        kernel_o     <= rd_data;
                        start_cnn_o  <= 1'b1;
                        busy_o       <= 1'b1;
                        cfg_ready_o  <= 1'b0;
                     end else begin
                        err_o <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (conv_px_rdy_i) begin
                     if (px_cnt == frame_px - 1'b1) begin
                        state        <= GAP;
                        px_cnt       <= '0;
                        gap_cnt      <= '0;
                        start_cnn_o  <= 1'b0;
                        layer_done_o <= 1'b1;
                     end else begin
                        px_cnt <= px_cnt + 1'b1;
                     end
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                     gap_cnt <= '0;
                     if (kernel_idx_o < LAST_KERNEL) begin
                        state        <= RUN;
                        kernel_idx_o <= kernel_idx_o + KIDX_W'(1);
                        kernel_o     <= rd_data;
                        start_cnn_o  <= 1'b1;
                     end else begin
                        state  <= DONE;
                        done_o <= 1'b1;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               DONE: begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  cfg_ready_o <= 1'b1;
               end
               default: begin
                  state       <= IDLE;
                  start_cnn_o <= 1'b0;
                  busy_o      <= 1'b0;
                  cfg_ready_o <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer (2 kernels, 2-cycle gap) with hand-computed
// expectations for load, sequencing, errors, abort and asynchronous reset.
module tb_conv_sequencer;
   import conv_sequencer_pkg::*;

   logic                           clk_i;
   logic                           nreset_i;
   logic                           cfg_valid_i;
   logic [PIXEL_WIDTH_OUT-1:0]     cfg_coef_i;
   logic                           cfg_ready_o;
   logic                           loaded_o;
   logic                           run_i;
   logic                           abort_i;
   logic [MAX_RESOLUTION_BITS-1:0] frame_px_i;
   logic                           conv_px_rdy_i;
   matrix_3x3                      kernel_o;
   logic                           start_cnn_o;
   logic [1:0]                     kernel_idx_o;
   logic                           busy_o;
   logic                           layer_done_o;
   logic                           done_o;
   logic                           err_o;

   int checks = 0;
   int errors = 0;

   conv_sequencer #(
      .NUM_KERNELS (2),
      .GAP_CYCLES  (2)
   ) dut (
      .clk_i         (clk_i),
      .nreset_i      (nreset_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_coef_i    (cfg_coef_i),
      .cfg_ready_o   (cfg_ready_o),
      .loaded_o      (loaded_o),
      .run_i         (run_i),
      .abort_i       (abort_i),
      .frame_px_i    (frame_px_i),
      .conv_px_rdy_i (conv_px_rdy_i),
      .kernel_o      (kernel_o),
      .start_cnn_o   (start_cnn_o),
      .kernel_idx_o  (kernel_idx_o),
      .busy_o        (busy_o),
      .layer_done_o  (layer_done_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive single-cycle control pulses for one clock, then release them.
   task automatic applyStimulus(input logic run, input logic rdy, input logic abort);
      run_i         = run;
      conv_px_rdy_i = rdy;
      abort_i       = abort;
      tick();
      run_i         = 1'b0;
      conv_px_rdy_i = 1'b0;
      abort_i       = 1'b0;
   endtask

   task automatic loadCoefs(input int base);
      for (int i = 0; i < 18; i++) begin
         cfg_valid_i = 1'b1;
         cfg_coef_i  = PIXEL_WIDTH_OUT'(base + i);
         tick();
         if (i == 16) checkOutput("load_not_yet", 32'(loaded_o), 0);
      end
      cfg_valid_i = 1'b0;
      checkOutput("load_done", 32'(loaded_o), 1);
   endtask

   initial begin
      nreset_i      = 1'b0;
      cfg_valid_i   = 1'b0;
      cfg_coef_i    = '0;
      run_i         = 1'b0;
      abort_i       = 1'b0;
      frame_px_i    = '0;
      conv_px_rdy_i = 1'b0;
      tick();
      tick();
      nreset_i = 1'b1;
      tick();

      $display("[TB] reset values");
      checkOutput("rst_cfg_ready", 32'(cfg_ready_o), 1);
      checkOutput("rst_loaded", 32'(loaded_o), 0);
      checkOutput("rst_start", 32'(start_cnn_o), 0);
      checkOutput("rst_busy", 32'(busy_o), 0);
      checkOutput("rst_err", 32'(err_o), 0);
      checkOutput("rst_done", 32'(done_o), 0);
      checkOutput("rst_idx", 32'(kernel_idx_o), 0);
      checkOutput("rst_kernel_zero", 32'(kernel_o != '0), 0);

      $display("[TB] run before load");
      frame_px_i = 16'd4;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("err_unloaded", 32'(err_o), 1);
      checkOutput("err_unloaded_busy", 32'(busy_o), 0);

      $display("[TB] load bank 1..18");
      loadCoefs(1);

      $display("[TB] run with frame_px=0");
      frame_px_i = 16'd0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fpx0_busy", 32'(busy_o), 0);
      checkOutput("fpx0_start", 32'(start_cnn_o), 0);
      checkOutput("fpx0_err", 32'(err_o), 1);

      $display("[TB] run and abort together");
      frame_px_i = 16'd4;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("run_abort_busy", 32'(busy_o), 0);

      $display("[TB] full two-kernel sequence");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("run0_start", 32'(start_cnn_o), 1);
      checkOutput("run0_busy", 32'(busy_o), 1);
      checkOutput("run0_cfg_ready", 32'(cfg_ready_o), 0);
      checkOutput("run0_idx", 32'(kernel_idx_o), 0);
      checkOutput("run0_k_v0p0", 32'(kernel_o.vector0.p0), 1);
      checkOutput("run0_k_v1p1", 32'(kernel_o.vector1.p1), 5);
      checkOutput("run0_k_v2p2", 32'(kernel_o.vector2.p2), 9);
      cfg_valid_i = 1'b1;
      cfg_coef_i  = 16'd99;
      applyStimulus(1'b0, 1'b1, 1'b0);
      cfg_valid_i = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("run0_p3_start", 32'(start_cnn_o), 1);
      checkOutput("run0_p3_ldone", 32'(layer_done_o), 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("gap0a_start", 32'(start_cnn_o), 0);
      checkOutput("gap0a_ldone", 32'(layer_done_o), 1);
      checkOutput("gap0a_busy", 32'(busy_o), 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("gap0b_start", 32'(start_cnn_o), 0);
      checkOutput("gap0b_ldone", 32'(layer_done_o), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("run1_start", 32'(start_cnn_o), 1);
      checkOutput("run1_idx", 32'(kernel_idx_o), 1);
      checkOutput("run1_k_v0p0", 32'(kernel_o.vector0.p0), 10);
      checkOutput("run1_k_v2p2", 32'(kernel_o.vector2.p2), 18);
      for (int p = 0; p < 3; p++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("run1_p3_start", 32'(start_cnn_o), 1);
      checkOutput("run1_p3_ldone", 32'(layer_done_o), 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("gap1a_ldone", 32'(layer_done_o), 1);
      checkOutput("gap1a_start", 32'(start_cnn_o), 0);
      tick();
      checkOutput("gap1b_start", 32'(start_cnn_o), 0);
      checkOutput("gap1b_done", 32'(done_o), 0);
      tick();
      checkOutput("done_pulse", 32'(done_o), 1);
      checkOutput("done_busy", 32'(busy_o), 1);
      checkOutput("done_start", 32'(start_cnn_o), 0);
      checkOutput("done_k_hold", 32'(kernel_o.vector0.p0), 10);
      tick();
      checkOutput("idle_done", 32'(done_o), 0);
      checkOutput("idle_busy", 32'(busy_o), 0);
      checkOutput("idle_cfg_ready", 32'(cfg_ready_o), 1);
      checkOutput("idle_err_sticky", 32'(err_o), 1);

      $display("[TB] abort in second layer");
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int p = 0; p < 4; p++) applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("abort_pre_idx", 32'(kernel_idx_o), 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("abort_busy", 32'(busy_o), 0);
      checkOutput("abort_start", 32'(start_cnn_o), 0);
      checkOutput("abort_idx", 32'(kernel_idx_o), 0);
      checkOutput("abort_done", 32'(done_o), 0);
      checkOutput("abort_ldone", 32'(layer_done_o), 0);
      checkOutput("abort_loaded", 32'(loaded_o), 1);
      checkOutput("abort_cfg_ready", 32'(cfg_ready_o), 1);
      tick();
      checkOutput("abort_after_done", 32'(done_o), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("rerun_busy", 32'(busy_o), 1);
      checkOutput("rerun_start", 32'(start_cnn_o), 1);
      checkOutput("rerun_idx", 32'(kernel_idx_o), 0);
      checkOutput("rerun_k_v0p0", 32'(kernel_o.vector0.p0), 1);

      $display("[TB] asynchronous reset mid-run");
      applyStimulus(1'b0, 1'b1, 1'b0);
      #3;
      nreset_i = 1'b0;
      #1;
      checkOutput("arst_start", 32'(start_cnn_o), 0);
      checkOutput("arst_busy", 32'(busy_o), 0);
      checkOutput("arst_loaded", 32'(loaded_o), 0);
      checkOutput("arst_cfg_ready", 32'(cfg_ready_o), 1);
      checkOutput("arst_err", 32'(err_o), 0);
      checkOutput("arst_kernel_zero", 32'(kernel_o != '0), 0);
      #2;
      nreset_i = 1'b1;
      tick();
      frame_px_i = 16'd4;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("arst_run_busy", 32'(busy_o), 0);
      checkOutput("arst_run_err", 32'(err_o), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
